pipe_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage CPU. It drives the write enables and bubble-flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and holds the whole pipeline while a variable-latency data-memory access completes. It also resolves load-use and taken-branch hazards and reports a sticky memory-timeout error and a stall-cycle count. It sits beside the pipeline registers, between hazard detection, the EX/MEM stage and the data memory.

---
 rtl/pipe_stall_ctrl_pkg.sv | 21 ++
 rtl/pipe_stall_ctrl_if.sv | 41 ++++
 rtl/pipe_stall_ctrl_sat_counter.sv | 32 +++
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and helpers for the pipeline stall controller.
//   state_e          : controller state (RUN, WAIT, ERROR)
//   MEM_TIMEOUT_DFLT : default WAIT-cycle budget before a memory timeout
//   wait_cnt_width() : width of the WAIT-cycle counter for a given budget,
//                      $clog2(MEM_TIMEOUT+1)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_e;

  localparam int unsigned MEM_TIMEOUT_DFLT = 255;

  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// pipe_stall_ctrl_if
// Bundles every controller signal except clock and reset.
//   Inputs to the controller : start_i, MemRead_i, MemWrite_i, mem_ack_i,
//                              LoadUse_i, BranchTaken_i
//   Outputs of the controller: mem_req_o, pc/if_id/id_ex/ex_mem/mem_wb enables,
//                              if_id/id_ex flushes, mem_timeout_o,
//                              stall_cnt_o[CNT_W], busy_o
// master = controller side, slave = pipeline / memory side.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start_i;
  logic             MemRead_i;
  logic             MemWrite_i;
  logic             mem_ack_i;
  logic             LoadUse_i;
  logic             BranchTaken_i;
  logic             mem_req_o;
  logic             pc_en_o;
  logic             if_id_en_o;
  logic             id_ex_en_o;
  logic             ex_mem_en_o;
  logic             mem_wb_en_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             busy_o;

  modport master (
    input  start_i, MemRead_i, MemWrite_i, mem_ack_i, LoadUse_i, BranchTaken_i,
    output mem_req_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_flush_o, id_ex_flush_o, mem_timeout_o, stall_cnt_o, busy_o
  );

  modport slave (
    output start_i, MemRead_i, MemWrite_i, mem_ack_i, LoadUse_i, BranchTaken_i,
    input  mem_req_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_flush_o, id_ex_flush_o, mem_timeout_o, stall_cnt_o, busy_o
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset, clears the count
//   i_clr   : synchronous clear, wins over i_inc
//   i_inc   : add one this cycle (ignored once saturated)
//   o_cnt   : current count [W]
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Sequencing controller for the 5-stage pipeline: drives per-stage load
// enables and bubble flushes, freezes the pipeline while a data-memory access
// is outstanding, resolves load-use and taken-branch hazards, flags a sticky
// memory timeout and counts stall cycles.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : pipe_stall_ctrl_if.master (hazard/memory inputs, enables,
//             flushes, mem_req_o, mem_timeout_o, stall_cnt_o, busy_o)
// All outputs except mem_timeout_o and stall_cnt_o are combinational from the
// state and the current inputs.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DFLT,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk_i,
  input logic               rst_n_i,
  pipe_stall_ctrl_if.master bus
);

  localparam int unsigned       WAIT_W    = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  // Enable order {pc, if_id, id_ex, ex_mem, mem_wb}: load-use holds the front
  // two stages and lets the rest advance behind a bubble.
  localparam logic [4:0]        EN_LOAD_USE = 5'b00111;

  state_e            r_state;
  logic              r_mem_timeout;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic [CNT_W-1:0]  w_stall_cnt;
  logic              w_mem_op;
  logic              w_req;
  logic [4:0]        w_en;
  logic              w_if_id_flush;
  logic              w_id_ex_flush;
  logic              w_stall_inc;

  assign w_mem_op = bus.MemRead_i | bus.MemWrite_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= RUN;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.start_i && w_mem_op && !bus.mem_ack_i) r_state <= WAIT;
        end
        WAIT: begin
          // A late ack on the would-be timeout edge still completes the access.
          if (bus.mem_ack_i) begin
            r_state <= RUN;
          end else if (w_wait_cnt == WAIT_LAST) begin
            r_state       <= ERROR;
            r_mem_timeout <= 1'b1;
          end
        end
        ERROR:   r_state <= ERROR;
        default: r_state <= RUN;
      endcase
    end
  end

  // Priority: memory stall, then load-use, then taken branch.
  always_comb begin
    w_req         = 1'b0;
    w_en          = '0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    if (rst_n_i) begin
      case (r_state)
        RUN: begin
          if (bus.start_i) begin
            if (w_mem_op) begin
              w_req = 1'b1;
              if (bus.mem_ack_i) w_en = '1;
            end else if (bus.LoadUse_i) begin
              w_en          = EN_LOAD_USE;
              w_id_ex_flush = 1'b1;
            end else begin
              w_en          = '1;
              w_if_id_flush = bus.BranchTaken_i;
            end
          end
        end
        WAIT: begin
          w_req = 1'b1;
          if (bus.mem_ack_i) w_en = '1;
        end
        default: ;
      endcase
    end
  end

  // start_i=0 in RUN idles the pipeline but is not a stall; WAIT always is.
  assign w_stall_inc = rst_n_i && !w_en[4] && (r_state != ERROR) &&
                       ((r_state == WAIT) || bus.start_i);

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_clr   (r_state != WAIT),
    .i_inc   ((r_state == WAIT) && !bus.mem_ack_i),
    .o_cnt   (w_wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_clr   (1'b0),
    .i_inc   (w_stall_inc),
    .o_cnt   (w_stall_cnt)
  );

  assign bus.mem_req_o     = w_req;
  assign bus.pc_en_o       = w_en[4];
  assign bus.if_id_en_o    = w_en[3];
  assign bus.id_ex_en_o    = w_en[2];
  assign bus.ex_mem_en_o   = w_en[1];
  assign bus.mem_wb_en_o   = w_en[0];
  assign bus.if_id_flush_o = w_if_id_flush;
  assign bus.id_ex_flush_o = w_id_ex_flush;
  assign bus.mem_timeout_o = r_mem_timeout;
  assign bus.stall_cnt_o   = w_stall_cnt;
  assign bus.busy_o        = rst_n_i && (r_state == WAIT);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl (MEM_TIMEOUT=4, 6-bit stall counter so that
// saturation at 63 is reachable).
module tb_pipe_stall_ctrl;

  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 6;
  localparam int          SMAX = 63;

  // obs = {req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //        if_id_flush, id_ex_flush, mem_timeout, busy}
  localparam logic [9:0] O_ZERO   = 10'b0_00000_00_0_0;
  localparam logic [9:0] O_RUN    = 10'b0_11111_00_0_0;
  localparam logic [9:0] O_REQSTL = 10'b1_00000_00_0_0;
  localparam logic [9:0] O_WAITST = 10'b1_00000_00_0_1;
  localparam logic [9:0] O_ACKRUN = 10'b1_11111_00_0_0;
  localparam logic [9:0] O_ACKWT  = 10'b1_11111_00_0_1;
  localparam logic [9:0] O_LU     = 10'b0_00111_01_0_0;
  localparam logic [9:0] O_BR     = 10'b0_11111_10_0_0;
  localparam logic [9:0] O_ERR    = 10'b0_00000_00_1_0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  pipe_stall_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  logic [9:0] obs;
  assign obs = {bus.mem_req_o, bus.pc_en_o, bus.if_id_en_o, bus.id_ex_en_o,
                bus.ex_mem_en_o, bus.mem_wb_en_o, bus.if_id_flush_o,
                bus.id_ex_flush_o, bus.mem_timeout_o, bus.busy_o};

  task automatic drive(input logic s, rd, wr, ack, lu, br);
    bus.start_i       = s;
    bus.MemRead_i     = rd;
    bus.MemWrite_i    = wr;
    bus.mem_ack_i     = ack;
    bus.LoadUse_i     = lu;
    bus.BranchTaken_i = br;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #2;
    n_vec++;
    if (obs !== O_ZERO) begin
      n_err++; $display("FAIL reset_outputs: got %b want %b", obs, O_ZERO);
    end
    n_vec++;
    if (bus.stall_cnt_o !== 6'd0) begin
      n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_RUN) begin
      n_err++; $display("FAIL reset_run_state: got %b want %b", obs, O_RUN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_latency();
    int busy_n = 0;
    int frz_n  = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 0, (c == 3), 0, 0);
      @(negedge clk);
      if (bus.busy_o) busy_n++;
      if (!bus.pc_en_o && !bus.mem_wb_en_o) frz_n++;
      if (c == 0) begin
        n_vec++;
        if (obs !== O_REQSTL) begin
          n_err++; $display("FAIL load_first_req: got %b want %b", obs, O_REQSTL);
        end
      end
      if (c == 3) begin
        n_vec++;
        if (obs !== O_ACKWT) begin
          n_err++; $display("FAIL load_ack_cycle: got %b want %b", obs, O_ACKWT);
        end
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (busy_n != 3) begin
      n_err++; $display("FAIL load_busy_cycles: got %0d want 3", busy_n);
    end
    n_vec++;
    if (frz_n != 3) begin
      n_err++; $display("FAIL load_frozen_cycles: got %0d want 3", frz_n);
    end
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_RUN || bus.stall_cnt_o !== 6'd3) begin
      n_err++; $display("FAIL load_after: got %b cnt %0d want %b cnt 3", obs, bus.stall_cnt_o, O_RUN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_same_cycle();
    do_reset();
    drive(1, 0, 1, 1, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_ACKRUN) begin
      n_err++; $display("FAIL store_ack0: got %b want %b", obs, O_ACKRUN);
    end
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_RUN || bus.stall_cnt_o !== 6'd0) begin
      n_err++; $display("FAIL store_after: got %b cnt %0d want %b cnt 0", obs, bus.stall_cnt_o, O_RUN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_loaduse_branch();
    do_reset();
    drive(1, 0, 0, 0, 1, 1);
    @(negedge clk);
    n_vec++;
    if (obs !== O_LU) begin
      n_err++; $display("FAIL loaduse_over_branch: got %b want %b", obs, O_LU);
    end
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    n_vec++;
    if (obs !== O_BR || bus.stall_cnt_o !== 6'd1) begin
      n_err++; $display("FAIL branch_flush: got %b cnt %0d want %b cnt 1", obs, bus.stall_cnt_o, O_BR);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int req_n = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, 0, 0, 0, 0);
      @(negedge clk);
      if (bus.mem_req_o) req_n++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (req_n != TO + 1) begin
      n_err++; $display("FAIL timeout_req_cycles: got %0d want %0d", req_n, TO + 1);
    end
    @(negedge clk);
    n_vec++;
    if (obs !== O_ERR || bus.stall_cnt_o !== 6'(TO + 1)) begin
      n_err++; $display("FAIL timeout_error_state: got %b cnt %0d want %b cnt %0d", obs, bus.stall_cnt_o, O_ERR, TO + 1);
    end
    @(posedge clk); #1;
    drive(1, 1, 0, 1, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_ERR) begin
      n_err++; $display("FAIL timeout_ack_ignored: got %b want %b", obs, O_ERR);
    end
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    n_vec++;
    if (obs !== O_ZERO || bus.stall_cnt_o !== 6'd0) begin
      n_err++; $display("FAIL timeout_reset_recovers: got %b cnt %0d want %b cnt 0", obs, bus.stall_cnt_o, O_ZERO);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (obs !== O_WAITST) begin
      n_err++; $display("FAIL midwait_in_wait: got %b want %b", obs, O_WAITST);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs !== O_ZERO || bus.stall_cnt_o !== 6'd0) begin
      n_err++; $display("FAIL midwait_async_drop: got %b cnt %0d want %b cnt 0", obs, bus.stall_cnt_o, O_ZERO);
    end
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_RUN || bus.stall_cnt_o !== 6'd0) begin
      n_err++; $display("FAIL midwait_after_release: got %b cnt %0d want %b cnt 0", obs, bus.stall_cnt_o, O_RUN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_low();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(0, 1, 0, 0, 0, 0);
      @(negedge clk);
      n_vec++;
      if (obs !== O_ZERO || bus.stall_cnt_o !== 6'd0) begin
        n_err++; $display("FAIL start_low_idle[%0d]: got %b cnt %0d want %b cnt 0", c, obs, bus.stall_cnt_o, O_ZERO);
      end
      @(posedge clk); #1;
    end
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_REQSTL) begin
      n_err++; $display("FAIL start_rise_req: got %b want %b", obs, O_REQSTL);
    end
    @(posedge clk); #1;
    drive(1, 1, 0, 1, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_ACKWT) begin
      n_err++; $display("FAIL start_rise_ack: got %b want %b", obs, O_ACKWT);
    end
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_vec++;
    if (obs !== O_RUN || bus.stall_cnt_o !== 6'd1) begin
      n_err++; $display("FAIL start_rise_after: got %b cnt %0d want %b cnt 1", obs, bus.stall_cnt_o, O_RUN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 70; c++) begin
      drive(1, 0, 0, 0, 1, 0);
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_vec++;
    if (bus.stall_cnt_o !== 6'(SMAX)) begin
      n_err++; $display("FAIL stall_saturate: got %0d want %0d", bus.stall_cnt_o, SMAX);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (bus.stall_cnt_o !== 6'(SMAX)) begin
      n_err++; $display("FAIL stall_saturate_hold: got %0d want %0d", bus.stall_cnt_o, SMAX);
    end
    @(posedge clk); #1;
  endtask

  // Reference model: tracks whether a memory access is outstanding, how long
  // it has been outstanding, whether it timed out, and the stall total.
  task automatic test_random();
    bit         pending;
    bit         dead;
    int         waited;
    int         stalls;
    logic       s, rd, wr, ack, lu, br;
    logic       req, ifl, idl;
    logic [4:0] en;
    logic [9:0] exp;
    do_reset();
    pending = 0; dead = 0; waited = 0; stalls = 0;
    for (int i = 0; i < 1500; i++) begin
      if (dead && $urandom_range(0, 3) == 0) begin
        do_reset();
        pending = 0; dead = 0; waited = 0; stalls = 0;
      end
      s   = ($urandom_range(0, 99) < 85);
      rd  = ($urandom_range(0, 3) == 0);
      wr  = ($urandom_range(0, 5) == 0);
      ack = ($urandom_range(0, 99) < 40);
      lu  = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 3) == 0);
      drive(s, rd, wr, ack, lu, br);
      req = 0; en = 5'b00000; ifl = 0; idl = 0;
      if (dead) begin
        // everything held low
      end else if (pending) begin
        req = 1;
        en  = ack ? 5'b11111 : 5'b00000;
      end else if (s && (rd || wr)) begin
        req = 1;
        en  = ack ? 5'b11111 : 5'b00000;
      end else if (s && lu) begin
        en  = 5'b00111;
        idl = 1;
      end else if (s) begin
        en  = 5'b11111;
        ifl = br;
      end
      exp = {req, en, ifl, idl, dead, pending};
      @(negedge clk);
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL random_outputs[%0d]: got %b want %b", i, obs, exp);
      end
      n_vec++;
      if (bus.stall_cnt_o !== 6'(stalls)) begin
        n_err++; $display("FAIL random_stall_cnt[%0d]: got %0d want %0d", i, bus.stall_cnt_o, stalls);
      end
      if (!dead && !en[4] && (pending || s) && stalls < SMAX) stalls++;
      if (!dead) begin
        if (pending) begin
          if (ack) pending = 0;
          else if (waited + 1 >= TO) begin pending = 0; dead = 1; end
          else waited++;
        end else if (s && (rd || wr) && !ack) begin
          pending = 1;
          waited  = 0;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_latency();
    test_store_same_cycle();
    test_loaduse_branch();
    test_timeout();
    test_reset_mid_wait();
    test_start_low();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
